seq_div_top: RTL and testbench
==============================

// Module: seq_div_top
// PURPOSE
//  Sequential unsigned restoring divider, split into control FSM + datapath.
//  Counterpart of the repeated-addition multiplier: same start/done handshake.
//  Same serial operand load on a shared data bus: dividend first, then divisor.
//  Produces quotient and remainder in WIDTH iteration cycles.
// PARAMETERS
//  WIDTH  16  operand/quotient/remainder width in bits (>=2)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  data       in   WIDTH  shared operand bus: dividend, then divisor
//  quotient   out  WIDTH  registered result
//  remainder  out  WIDTH  registered result (only with DIV_REMAINDER_EN)
//  dz         out  1      divide-by-zero flag for last operation
//  busy       out  1      high in LD_A, LD_B, CALC
//  done       out  1      high exactly one cycle, in DONE state
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; A, B, R, Q, count=0.
//   quotient=0, remainder=0, dz=0, busy=0, done=0.
//   Reset anywhere mid-operation aborts it; no done pulse is produced.
//  Timing: edge0 samples start=1 in IDLE.
//   edge1 samples dividend; edge2 samples divisor.
//  FSM states and transitions:
//   IDLE: start=1 -> LD_A; otherwise stay.
//   LD_A: A<=data -> LD_B.
//   LD_B: B<=data; R<=0; Q<=A; count<=WIDTH.
//    data==0 -> DONE; there quotient<=all-ones, remainder<=A, dz<=1.
//    otherwise -> CALC.
//   CALC, one step per edge:
//    T={R[WIDTH-1:0],Q[WIDTH-1]} (WIDTH+1 bits).
//    T>=B -> R<=T-B, Q<={Q[WIDTH-2:0],1}; else R<=T, Q<={Q[WIDTH-2:0],0}.
//    count decrements each step.
//    At the step where count==1: -> DONE; quotient<=next Q, remainder<=next R, dz<=0.
//   DONE: done=1 (decoded from state) -> IDLE unconditionally.
//  Latency: done high in the cycle after edge WIDTH+2; only after edge2 when dz.
//  Start is ignored in LD_A, LD_B, CALC and DONE; no queuing.
//   Earliest re-accept is the IDLE cycle after DONE.
//  Outputs quotient, remainder and dz change only on DONE entry or reset.
//   They hold until the next completed operation.
//  R never exceeds B-1 < 2^WIDTH, so R stays WIDTH bits.
//   Only the compare/subtract temp T is WIDTH+1 bits.
// CONFIGURATION
//  DIV_REMAINDER_EN defined: remainder port and output register exist as above.
//  DIV_REMAINDER_EN undefined: remainder port and register removed.
//   Working R is still kept internally; quotient, dz and timing are identical.
// STRUCTURE
//  Shared package/header div_defs.vh holds:
//   state encodings (IDLE, LD_A, LD_B, CALC, DONE; 3-bit);
//   default WIDTH; count width = $clog2(WIDTH+1).
//  Sub-module div_control: FSM and counter.
//   It outputs ldA, ldB, clrR, shift, ldOut and setDz.
//   It takes eqz (divisor==0) and cnt1 (count==1) from the datapath.
//  The top level holds the datapath registers.
// TESTING
//  1 17/5: start, data=17 then 5 -> quotient=3, remainder=2, dz=0; done at edge WIDTH+2 (=18).
//  2 5/17 -> quotient=0, remainder=5.
//   65535/1 -> quotient=65535, remainder=0.
//   0/7 -> 0, 0.
//  3 100/0 -> done after edge2, dz=1, quotient=16'hFFFF, remainder=100.
//   The next valid op (9/3) clears dz: quotient=3, remainder=0.
//  4 start held high for the whole of the 17/5 operation.
//   -> exactly one done pulse, results unchanged during CALC.
//   -> a new LD_A begins only after the IDLE cycle.
//  5 rst=1 mid-CALC -> next cycle IDLE, all outputs 0, no done.
//   A fresh 40000/123 -> quotient=325, remainder=25.
//  6 Random 1000 pairs with divisor!=0 vs reference model a/b, a%b.
//   Build with and without DIV_REMAINDER_EN; the quotient stream must match.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and iteration-counter width.
package seq_div_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLdA  = 3'd1,
    StLdB  = 3'd2,
    StCalc = 3'd3,
    StDone = 3'd4
  } div_state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_div_control.sv
// Control FSM of the sequential divider: operand load sequencing, iteration
// stepping and the single-cycle done pulse.
module seq_div_control
  import seq_div_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic eqz_i,
  input  logic cnt1_i,
  output logic ld_a_o,
  output logic ld_b_o,
  output logic clr_r_o,
  output logic shift_o,
  output logic ld_out_o,
  output logic set_dz_o,
  output logic busy_o,
  output logic done_o
);

  div_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLdA;
      StLdA:   state_d = StLdB;
      StLdB:   state_d = eqz_i ? StDone : StCalc;
      StCalc:  if (cnt1_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ld_a_o   = 1'b0;
    ld_b_o   = 1'b0;
    clr_r_o  = 1'b0;
    shift_o  = 1'b0;
    ld_out_o = 1'b0;
    set_dz_o = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      StLdA: begin
        ld_a_o = 1'b1;
        busy_o = 1'b1;
      end
      StLdB: begin
        ld_b_o   = 1'b1;
        clr_r_o  = 1'b1;
        busy_o   = 1'b1;
        ld_out_o = eqz_i;
        set_dz_o = eqz_i;
      end
      StCalc: begin
        shift_o  = 1'b1;
        busy_o   = 1'b1;
        ld_out_o = cnt1_i;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_div_top.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Define DIV_REMAINDER_EN to expose the registered remainder output.
module seq_div_top
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] quotient_o,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder_o,
`endif
  output logic             dz_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic ld_a, ld_b, clr_r, shift, ld_out, set_dz, eqz, cnt1;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             dz_q, dz_d;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_q, rem_d;
`endif

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] r_next, q_next;

  seq_div_control u_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .eqz_i    (eqz),
    .cnt1_i   (cnt1),
    .ld_a_o   (ld_a),
    .ld_b_o   (ld_b),
    .clr_r_o  (clr_r),
    .shift_o  (shift),
    .ld_out_o (ld_out),
    .set_dz_o (set_dz),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  // The divisor is still on the bus while being loaded, so test it there.
  assign eqz = (data_i == '0);
  assign cnt1 = (count_q == CntW'(1));

  assign trial  = {r_q, q_q[WIDTH-1]};
  assign ge     = (trial >= {1'b0, b_q});
  // Remainder stays below B, so the WIDTH+1-bit difference always fits in WIDTH bits.
  assign r_next = WIDTH'(ge ? (trial - {1'b0, b_q}) : trial);
  assign q_next = {q_q[WIDTH-2:0], ge};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    count_d = count_q;
    quot_d  = quot_q;
    dz_d    = dz_q;
`ifdef DIV_REMAINDER_EN
    rem_d   = rem_q;
`endif
    if (ld_a) a_d = data_i;
    if (ld_b) begin
      b_d     = data_i;
      q_d     = a_q;
      count_d = CntW'(WIDTH);
    end
    if (clr_r) r_d = '0;
    if (shift) begin
      r_d     = r_next;
      q_d     = q_next;
      count_d = count_q - CntW'(1);
    end
    if (ld_out) begin
      if (set_dz) begin
        quot_d = '1;
        dz_d   = 1'b1;
`ifdef DIV_REMAINDER_EN
        rem_d  = a_q;
`endif
      end else begin
        quot_d = q_next;
        dz_d   = 1'b0;
`ifdef DIV_REMAINDER_EN
        rem_d  = r_next;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rem_q   <= '0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      dz_q    <= dz_d;
`ifdef DIV_REMAINDER_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign quotient_o  = quot_q;
  assign dz_o        = dz_q;
`ifdef DIV_REMAINDER_EN
  assign remainder_o = rem_q;
`endif

endmodule

// File: tb/tb_seq_div_top.sv
// Directed and random self-checking bench for seq_div_top; remainder checks
// are active only when DIV_REMAINDER_EN is defined.
module tb_seq_div_top;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data;
  logic [W-1:0] quotient;
`ifdef DIV_REMAINDER_EN
  logic [W-1:0] remainder;
`endif
  logic         dz, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div_top #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .data_i      (data),
    .quotient_o  (quotient),
`ifdef DIV_REMAINDER_EN
    .remainder_o (remainder),
`endif
    .dz_o        (dz),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_rem(input string tag, input logic [W-1:0] exp);
`ifdef DIV_REMAINDER_EN
    check_eq(tag, 32'(remainder), 32'(exp));
`else
    if (tag.len() == 0) $display("rem %0d", exp);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one operation; lat is the edge index after which done was first seen
  // (edge0 samples start), -1 if never. b1/b2 are busy one and two cycles later.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        output int lat, output int pulses, output logic b1, output logic b2);
    logic [W-1:0] q_hold;
    q_hold = quotient;
    lat    = -1;
    pulses = 0;
    b1     = 1'bx;
    b2     = 1'bx;
    @(negedge clk);
    start = 1'b1;
    data  = '0;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    data = a;
    @(posedge clk);
    @(negedge clk);
    data = b;
    @(posedge clk);
    for (int e = 2; e < int'(W) + 8; e++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) lat = e;
      end else if (lat < 0 && quotient !== q_hold) begin
        check_eq("q_stable", 32'(quotient), 32'(q_hold));
      end
      if (lat >= 0 && e == lat + 1) b1 = busy;
      if (lat >= 0 && e == lat + 2) b2 = busy;
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  logic [W-1:0] va [6] = '{16'd17, 16'd5, 16'd65535, 16'd0, 16'd100, 16'd9};
  logic [W-1:0] vb [6] = '{16'd5, 16'd17, 16'd1, 16'd7, 16'd0, 16'd3};
  logic [W-1:0] vq [6] = '{16'd3, 16'd0, 16'd65535, 16'd0, 16'hFFFF, 16'd3};
  logic [W-1:0] vr [6] = '{16'd2, 16'd5, 16'd0, 16'd0, 16'd100, 16'd0};
  logic         vz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat, pulses;
    logic b1, b2;
    logic [W-1:0] ra, rb;

    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q", 32'(quotient), 32'd0);
    check_rem("rst_r", '0);
    check_eq("rst_dz", 32'(dz), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], 1'b0, lat, pulses, b1, b2);
      check_eq($sformatf("lat_%0d", i), 32'(lat), vz[i] ? 32'd2 : 32'(W + 2));
      check_eq($sformatf("pulses_%0d", i), 32'(pulses), 32'd1);
      check_eq($sformatf("q_%0d", i), 32'(quotient), 32'(vq[i]));
      check_rem($sformatf("r_%0d", i), vr[i]);
      check_eq($sformatf("dz_%0d", i), 32'(dz), 32'(vz[i]));
    end

    // Start held high through a whole 17/5 operation.
    run_op(16'd5, 16'd17, 1'b0, lat, pulses, b1, b2);
    check_eq("pre_hold_q", 32'(quotient), 32'd0);
    run_op(16'd17, 16'd5, 1'b1, lat, pulses, b1, b2);
    check_eq("hold_lat", 32'(lat), 32'(W + 2));
    check_eq("hold_pulses", 32'(pulses), 32'd1);
    check_eq("hold_idle_busy", 32'(b1), 32'd0);
    check_eq("hold_reload_busy", 32'(b2), 32'd1);
    check_eq("hold_q", 32'(quotient), 32'd3);
    check_rem("hold_r", 16'd2);
    do_reset();

    // Reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data  = 16'd17;
    @(posedge clk);
    @(negedge clk);
    data = 16'd5;
    repeat (6) @(posedge clk);
    check_eq("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_q", 32'(quotient), 32'd0);
    check_eq("abort_dz", 32'(dz), 32'd0);
    check_rem("abort_r", '0);
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("abort_no_done", 32'(pulses), 32'd0);
    run_op(16'd40000, 16'd123, 1'b0, lat, pulses, b1, b2);
    check_eq("fresh_lat", 32'(lat), 32'(W + 2));
    check_eq("fresh_q", 32'(quotient), 32'd325);
    check_rem("fresh_r", 16'd25);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(1, 65535));
      run_op(ra, rb, 1'b0, lat, pulses, b1, b2);
      check_eq($sformatf("rnd_q %0d/%0d", ra, rb), 32'(quotient), 32'(ra / rb));
      check_rem($sformatf("rnd_r %0d/%0d", ra, rb), ra % rb);
      if (lat != int'(W + 2)) check_eq("rnd_lat", 32'(lat), 32'(W + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
